// File: rtl/drp_reconf_ctrl.sv
// PLL DRP reconfiguration sequencer: read-modify-write of up to 8 table entries with PLL held in reset.
// Optional DRDY timeout is built when DRP_TIMEOUT_EN is defined.
module drp_reconf_ctrl #(
   parameter int TABLE_DEPTH    = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        DCLK,
   input  logic        RST,
   input  logic        START,
   input  logic [3:0]  COUNT,
   input  logic        TBL_WE,
   input  logic [2:0]  TBL_IDX,
   input  logic [6:0]  TBL_DADDR,
   input  logic [15:0] TBL_MASK,
   input  logic [15:0] TBL_DATA,
   output logic [6:0]  DADDR,
   output logic        DEN,
   output logic        DWE,
   output logic [15:0] DI,
   input  logic [15:0] DO,
   input  logic        DRDY,
   output logic        PLL_RST,
   input  logic        LOCKED,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERROR
);

   // state     | meaning
   // IDLE      | waiting for START; table writable
   // READ      | one-cycle DRP read strobe for current entry
   // WAIT_RD   | waiting for DRDY, captures DO
   // WRITE     | one-cycle DRP write strobe with merged data
   // WAIT_WR   | waiting for write DRDY, then next entry or release
   // RELEASE   | drops PLL reset
   // WAIT_LOCK | waiting for LOCKED, then DONE
   typedef enum logic [2:0] {
      IDLE, READ, WAIT_RD, WRITE, WAIT_WR, RELEASE, WAIT_LOCK
   } state_t;

   state_t      state_q, state_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        pll_rst_q, pll_rst_d;
   logic [3:0]  count_q, count_d;
   logic [2:0]  idx_q, idx_d;
   logic [15:0] do_q, do_d;
   logic        last_entry;

   logic [6:0]  tbl_addr [TABLE_DEPTH];
   logic [15:0] tbl_mask [TABLE_DEPTH];
   logic [15:0] tbl_data [TABLE_DEPTH];

`ifdef DRP_TIMEOUT_EN
   localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             error_q, error_d;
   logic             tmr_tc;
   assign tmr_tc = (tmr_q == '0);
`endif

   // Table has no reset so a replay after RST reuses the same entries.
   always_ff @(posedge DCLK) begin
      if (TBL_WE && !busy_q) begin
         tbl_addr[TBL_IDX] <= TBL_DADDR;
         tbl_mask[TBL_IDX] <= TBL_MASK;
         tbl_data[TBL_IDX] <= TBL_DATA;
      end
   end

   assign last_entry = ({1'b0, idx_q} == (count_q - 4'd1));

   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      pll_rst_d = pll_rst_q;
      count_d   = count_q;
      idx_d     = idx_q;
      do_d      = do_q;
`ifdef DRP_TIMEOUT_EN
      tmr_d     = tmr_q;
      error_d   = error_q;
`endif
      case (state_q)
         IDLE: begin
            if (START) begin
`ifdef DRP_TIMEOUT_EN
               error_d = 1'b0;
`endif
               if (COUNT == 4'd0) begin
                  done_d = 1'b1;
               end else begin
                  count_d   = (COUNT > 4'(TABLE_DEPTH)) ? 4'(TABLE_DEPTH) : COUNT;
                  idx_d     = 3'd0;
                  busy_d    = 1'b1;
                  pll_rst_d = 1'b1;
                  state_d   = READ;
               end
            end
         end
         READ: begin
            state_d = WAIT_RD;
`ifdef DRP_TIMEOUT_EN
            tmr_d = TMR_LOAD;
`endif
         end
         WAIT_RD: begin
            if (DRDY) begin
               do_d    = DO;
               state_d = WRITE;
            end
`ifdef DRP_TIMEOUT_EN
            else if (tmr_tc) begin
               error_d   = 1'b1;
               pll_rst_d = 1'b0;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = IDLE;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
`endif
         end
         WRITE: begin
            state_d = WAIT_WR;
`ifdef DRP_TIMEOUT_EN
            tmr_d = TMR_LOAD;
`endif
         end
         WAIT_WR: begin
            if (DRDY) begin
               if (last_entry) begin
                  state_d = RELEASE;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = READ;
               end
            end
`ifdef DRP_TIMEOUT_EN
            else if (tmr_tc) begin
               error_d   = 1'b1;
               pll_rst_d = 1'b0;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = IDLE;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
`endif
         end
         RELEASE: begin
            pll_rst_d = 1'b0;
            state_d   = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (LOCKED) begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge DCLK) begin
      if (RST) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         pll_rst_q <= 1'b0;
         count_q   <= 4'd0;
         idx_q     <= 3'd0;
         do_q      <= 16'd0;
`ifdef DRP_TIMEOUT_EN
         tmr_q     <= '0;
         error_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         pll_rst_q <= pll_rst_d;
         count_q   <= count_d;
         idx_q     <= idx_d;
         do_q      <= do_d;
`ifdef DRP_TIMEOUT_EN
         tmr_q     <= tmr_d;
         error_q   <= error_d;
`endif
      end
   end

   // Keep bits come from the captured read value, the rest from the entry data.
   assign DEN     = (state_q == READ) || (state_q == WRITE);
   assign DWE     = (state_q == WRITE);
   assign DADDR   = DEN ? tbl_addr[idx_q] : 7'd0;
   assign DI      = DWE ? ((do_q & tbl_mask[idx_q]) | (tbl_data[idx_q] & ~tbl_mask[idx_q])) : 16'd0;
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign PLL_RST = pll_rst_q;
`ifdef DRP_TIMEOUT_EN
   assign ERROR   = error_q;
`else
   assign ERROR   = 1'b0;
`endif

endmodule
